// File: rtl/rgb888_fifo_unpacker.sv
// Unpacks a 128-bit FWFT FIFO stream into registered RGB888 pixels (16 pixels per 3 words).
// Optional macro RGB888_UNPACK_BGR_SWAP_EN reverses the byte order of each output pixel.
module rgb888_fifo_unpacker #(
  parameter int LINE_PIXELS = 640
) (
  input  logic         system_clk,
  input  logic         rst_n,
  input  logic         i_sync_clr,
  input  logic         i_fifo_empty,
  input  logic [127:0] i_fifo_rddata,
  output logic         o_fifo_rden,
  output logic         o_pix_valid,
  output logic [23:0]  o_pix_data,
  output logic         o_pix_last,
  input  logic         i_pix_ready
);

  localparam logic [15:0] LAST_CNT = 16'(LINE_PIXELS - 1);

  typedef enum logic [1:0] {
    PH0 = 2'd0,
    PH1 = 2'd1,
    PH2 = 2'd2
  } phase_t;

  phase_t       phase;
  phase_t       phase_nxt;
  logic [2:0]   pix_idx;
  logic [2:0]   pix_idx_nxt;
  logic [15:0]  carry;
  logic [15:0]  carry_nxt;
  logic [15:0]  pix_cnt;
  logic [15:0]  cnt_inc;
  logic [15:0]  load_cnt;
  logic         accept;
  logic         load_en;
  logic         word_last;
  logic [23:0]  pix_stream;

  logic         vld_p0;
  logic [23:0]  pix_data_p0;
  logic         pix_last_p0;

  // Pixel in stream order {byte 3p+2, byte 3p+1, byte 3p}; carry holds
  // leftover bytes of the previous word, oldest byte in carry[7:0].
  function automatic logic [23:0] select_pixel(input phase_t ph, input logic [2:0] idx,
                                               input logic [127:0] w, input logic [15:0] c);
    logic [6:0] base;
    base = 7'd24 * {4'd0, idx};
    case (ph)
      PH0: return w[base +: 24];
      PH1: begin
        if (idx == 3'd0) return {w[15:0], c[7:0]};
        return w[(base - 7'd8) +: 24];
      end
      PH2: begin
        if (idx == 3'd0) return {w[7:0], c[15:0]};
        return w[(base - 7'd16) +: 24];
      end
      default: return w[23:0];
    endcase
  endfunction

  function automatic logic [23:0] order_pixel(input logic [23:0] p);
`ifdef RGB888_UNPACK_BGR_SWAP_EN
    return {p[7:0], p[15:8], p[23:16]};
`else
    return p;
`endif
  endfunction

  assign accept    = vld_p0 && i_pix_ready;
  assign load_en   = rst_n && !i_sync_clr && !i_fifo_empty && (!vld_p0 || i_pix_ready);
  assign word_last = (phase == PH2) ? (pix_idx == 3'd5) : (pix_idx == 3'd4);
  assign o_fifo_rden = load_en && word_last;

  assign pix_stream = select_pixel(phase, pix_idx, i_fifo_rddata, carry);

  // A pixel loaded while the current one is accepted carries the next count.
  assign cnt_inc  = (pix_cnt == LAST_CNT) ? 16'd0 : pix_cnt + 16'd1;
  assign load_cnt = accept ? cnt_inc : pix_cnt;

  always_comb begin
    phase_nxt   = phase;
    pix_idx_nxt = pix_idx;
    carry_nxt   = carry;
    if (load_en) begin
      if (word_last) begin
        pix_idx_nxt = 3'd0;
        case (phase)
          PH0: begin
            phase_nxt = PH1;
            carry_nxt = {8'h00, i_fifo_rddata[127:120]};
          end
          PH1: begin
            phase_nxt = PH2;
            carry_nxt = i_fifo_rddata[127:112];
          end
          default: begin
            phase_nxt = PH0;
            carry_nxt = 16'h0000;
          end
        endcase
      end else begin
        pix_idx_nxt = pix_idx + 3'd1;
      end
    end
  end

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= PH0;
    end else if (i_sync_clr) begin
      phase <= PH0;
    end else begin
      phase <= phase_nxt;
    end
  end

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_idx <= 3'd0;
      carry   <= 16'h0000;
      pix_cnt <= 16'd0;
    end else if (i_sync_clr) begin
      pix_idx <= 3'd0;
      carry   <= 16'h0000;
      pix_cnt <= 16'd0;
    end else begin
      pix_idx <= pix_idx_nxt;
      carry   <= carry_nxt;
      if (accept) begin
        pix_cnt <= cnt_inc;
      end
    end
  end

  // Output stage p0
  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0      <= 1'b0;
      pix_data_p0 <= 24'h000000;
      pix_last_p0 <= 1'b0;
    end else if (i_sync_clr) begin
      vld_p0      <= 1'b0;
      pix_last_p0 <= 1'b0;
    end else if (load_en) begin
      vld_p0      <= 1'b1;
      pix_data_p0 <= order_pixel(pix_stream);
      pix_last_p0 <= (load_cnt == LAST_CNT);
    end else if (accept) begin
      vld_p0      <= 1'b0;
      pix_last_p0 <= 1'b0;
    end
  end

  assign o_pix_valid = vld_p0;
  assign o_pix_data  = pix_data_p0;
  assign o_pix_last  = pix_last_p0;

endmodule

// File: tb/tb_rgb888_fifo_unpacker.sv
// Directed bench for rgb888_fifo_unpacker with a first-word-fall-through FIFO model.
module tb_rgb888_fifo_unpacker;

  logic         system_clk;
  logic         rst_n;
  logic         i_sync_clr;
  logic         i_fifo_empty;
  logic [127:0] i_fifo_rddata;
  logic         o_fifo_rden;
  logic         o_pix_valid;
  logic [23:0]  o_pix_data;
  logic         o_pix_last;
  logic         i_pix_ready;

  rgb888_fifo_unpacker #(.LINE_PIXELS(16)) dut (
    .system_clk    (system_clk),
    .rst_n         (rst_n),
    .i_sync_clr    (i_sync_clr),
    .i_fifo_empty  (i_fifo_empty),
    .i_fifo_rddata (i_fifo_rddata),
    .o_fifo_rden   (o_fifo_rden),
    .o_pix_valid   (o_pix_valid),
    .o_pix_data    (o_pix_data),
    .o_pix_last    (o_pix_last),
    .i_pix_ready   (i_pix_ready)
  );

  initial begin
    system_clk = 1'b0;
    forever #5 system_clk = ~system_clk;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int rden_cnt = 0;
  int used;

  logic [127:0] fifo_q[$];
  logic [23:0]  got_d[$];
  logic         got_l[$];

  logic        v_s, l_s, rden_s;
  logic [23:0] d_s;
  logic        prev_ok, prev_v, prev_r, prev_l;
  logic [23:0] prev_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mkword(input int b);
    logic [127:0] w;
    for (int k = 0; k < 16; k++) w[8*k +: 8] = 8'(b + k);
    return w;
  endfunction

  function automatic logic [23:0] exp_pix(input int b, input int p);
    logic [7:0] b0, b1, b2;
    b0 = 8'(b + 3*p);
    b1 = 8'(b + 3*p + 1);
    b2 = 8'(b + 3*p + 2);
`ifdef RGB888_UNPACK_BGR_SWAP_EN
    return {b0, b1, b2};
`else
    return {b2, b1, b0};
`endif
  endfunction

  task automatic upd_fifo();
    i_fifo_empty  = (fifo_q.size() == 0);
    i_fifo_rddata = (fifo_q.size() != 0) ? fifo_q[0] : 128'h0;
  endtask

  task automatic push_words(input int b, input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(mkword(b + 16*i));
    upd_fifo();
  endtask

  task automatic flush_fifo();
    fifo_q.delete();
    upd_fifo();
  endtask

  task automatic clear_log();
    got_d.delete();
    got_l.delete();
    rden_cnt = 0;
  endtask

  // One clock: sample at the falling edge, then pop after the rising edge.
  task automatic tick();
    @(negedge system_clk);
    v_s    = o_pix_valid;
    d_s    = o_pix_data;
    l_s    = o_pix_last;
    rden_s = o_fifo_rden;
    if (rden_s && i_fifo_empty) chk("rden_while_empty", 32'(rden_s), 32'd0);
    if (rden_s) rden_cnt++;
    if (prev_ok && prev_v && !prev_r && rst_n) begin
      chk("hold_valid", 32'(v_s), 32'd1);
      chk("hold_data", 32'(d_s), 32'(prev_d));
      chk("hold_last", 32'(l_s), 32'(prev_l));
    end
    if (v_s && i_pix_ready && rst_n && !i_sync_clr) begin
      got_d.push_back(d_s);
      got_l.push_back(l_s);
    end
    prev_ok = rst_n && !i_sync_clr;
    prev_v  = v_s;
    prev_r  = i_pix_ready;
    prev_d  = d_s;
    prev_l  = l_s;
    @(posedge system_clk);
    #1;
    if (rden_s && fifo_q.size() != 0) void'(fifo_q.pop_front());
    upd_fifo();
  endtask

  task automatic collect(input int n, input int budget, output int ticks);
    ticks = 0;
    while (got_d.size() < n && ticks < budget) begin
      tick();
      ticks++;
    end
  endtask

  task automatic check_seq(input string tag, input int b, input int n);
    chk($sformatf("%s_count", tag), 32'(got_d.size()), 32'(n));
    for (int p = 0; p < n && p < got_d.size(); p++) begin
      chk($sformatf("%s_pix%0d", tag, p), 32'(got_d[p]), 32'(exp_pix(b, p)));
      chk($sformatf("%s_last%0d", tag, p), 32'(got_l[p]), 32'((p % 16) == 15));
    end
  endtask

  initial begin
    prev_ok = 1'b0; prev_v = 1'b0; prev_r = 1'b0; prev_l = 1'b0; prev_d = '0;
    rst_n = 1'b0;
    i_sync_clr = 1'b0;
    i_pix_ready = 1'b1;
    flush_fifo();

    // Reset state, with a word waiting in the FIFO
    push_words(8'h00, 1);
    tick();
    chk("rst_valid", 32'(v_s), 32'd0);
    chk("rst_data", 32'(d_s), 32'h0);
    chk("rst_last", 32'(l_s), 32'd0);
    chk("rst_rden", 32'(rden_s), 32'd0);
    flush_fifo();
    tick();
    rst_n = 1'b1;
    tick();

    // Three words, ready high: first valid one cycle after empty falls, then 1 pixel/cycle
    clear_log();
    push_words(8'h00, 3);
    tick();
    chk("first_vld_latency", 32'(v_s), 32'd0);
    collect(16, 40, used);
    chk("burst_ticks", 32'(used), 32'd16);
    check_seq("burst", 8'h00, 16);
`ifdef RGB888_UNPACK_BGR_SWAP_EN
    if (got_d.size() == 16) begin
      chk("burst_p0_const", 32'(got_d[0]), 32'h000102);
      chk("burst_p15_const", 32'(got_d[15]), 32'h2D2E2F);
    end
`else
    if (got_d.size() == 16) begin
      chk("burst_p0_const", 32'(got_d[0]), 32'h020100);
      chk("burst_p5_const", 32'(got_d[5]), 32'h11100F);
      chk("burst_p10_const", 32'(got_d[10]), 32'h201F1E);
      chk("burst_p15_const", 32'(got_d[15]), 32'h2F2E2D);
    end
`endif
    chk("burst_rden", 32'(rden_cnt), 32'd3);
    tick();
    chk("burst_drained", 32'(v_s), 32'd0);

    // FIFO empty after word0: gap with carry byte held, then resume
    clear_log();
    push_words(8'h00, 1);
    collect(5, 20, used);
    chk("gap_pre_count", 32'(got_d.size()), 32'd5);
    chk("gap_pre_rden", 32'(rden_cnt), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("gap_vld%0d", i), 32'(v_s), 32'd0);
    end
    fifo_q.push_back(mkword(8'h10));
    fifo_q.push_back(mkword(8'h20));
    upd_fifo();
    collect(16, 40, used);
    check_seq("gap", 8'h00, 16);
    chk("gap_rden", 32'(rden_cnt), 32'd3);

    // Ready toggling: each pixel held until accepted, no duplicate pops
    clear_log();
    push_words(8'h00, 3);
    i_pix_ready = 1'b0;
    used = 0;
    while (got_d.size() < 16 && used < 100) begin
      i_pix_ready = !i_pix_ready;
      tick();
      used++;
    end
    i_pix_ready = 1'b1;
    check_seq("toggle", 8'h00, 16);
    chk("toggle_rden", 32'(rden_cnt), 32'd3);
    tick();
    tick();

    // Six words: end-of-line marks on pixels 15 and 31
    clear_log();
    push_words(8'h00, 6);
    collect(32, 80, used);
    check_seq("line2", 8'h00, 32);
    chk("line2_rden", 32'(rden_cnt), 32'd6);
    tick();

    // Synchronous clear mid-line restarts phase and pixel count
    clear_log();
    push_words(8'h00, 3);
    collect(7, 30, used);
    i_sync_clr = 1'b1;
    tick();
    chk("clr_rden", 32'(rden_s), 32'd0);
    i_sync_clr = 1'b0;
    flush_fifo();
    tick();
    chk("clr_valid", 32'(v_s), 32'd0);
    chk("clr_last", 32'(l_s), 32'd0);
    clear_log();
    push_words(8'h80, 3);
    collect(16, 40, used);
    check_seq("clr", 8'h80, 16);
    tick();

    // Asynchronous reset after pixel 7, then a fresh burst
    clear_log();
    push_words(8'h00, 3);
    collect(8, 30, used);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_valid", 32'(v_s), 32'd0);
    chk("mid_rst_data", 32'(d_s), 32'h0);
    chk("mid_rst_last", 32'(l_s), 32'd0);
    chk("mid_rst_rden", 32'(rden_s), 32'd0);
    flush_fifo();
    tick();
    rst_n = 1'b1;
    tick();
    clear_log();
    push_words(8'h40, 3);
    collect(16, 40, used);
    check_seq("post_rst", 8'h40, 16);
`ifdef RGB888_UNPACK_BGR_SWAP_EN
    if (got_d.size() != 0) chk("post_rst_p0_const", 32'(got_d[0]), 32'h404142);
`else
    if (got_d.size() != 0) chk("post_rst_p0_const", 32'(got_d[0]), 32'h424140);
`endif
    chk("post_rst_rden", 32'(rden_cnt), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
